dmem_responder: RTL and testbench
=================================

# dmem_responder

Word-organised data memory that answers the pipeline's memory-stage load/store requests. It accepts one request at a time over a request/ready handshake and inserts a programmable number of wait states. It drives a busy signal so the hazard unit can hold the pipeline until the response arrives. Byte-lane write enables and misaligned-access detection are included.

## Interface
Parameters:
- DEPTH_LOG2, default 6: memory holds 2^DEPTH_LOG2 32-bit words.
- LATENCY, default 2: wait-state cycles between acceptance and response. Legal range 0..7.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low. When 0, state and outputs clear immediately.
- MemReq  input  1  request valid. Held with its fields stable until MemReady.
- MemWrite  input  1  1 = store, 0 = load.
- Addr  input  32  byte address.
- WriteData  input  32  store data.
- ByteEn  input  4  store lane enables. Bit i enables WriteData[8i+7:8i]. Ignored on loads.
- ReadData  output  32  registered load data. Holds its value between responses.
- MemReady  output  1  one-cycle response pulse.
- MemError  output  1  asserted together with MemReady when the request was misaligned.
- MemBusy  output  1  stall request to the hazard unit.

## Operation
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - When MemReq=1, the request is accepted. Addr, WriteData, MemWrite and ByteEn are latched.
  - The wait counter is loaded with LATENCY.
  - Next state is WAIT if LATENCY>0, otherwise RESP.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 1 (its final decrement), next state is RESP.
  - MemReq and its fields are ignored; the latched copy is used.
- Access: on the edge entering RESP, the array access is performed.
  - Word index = latched Addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias modulo the memory size.
  - Store: each enabled lane is written. ByteEn=0000 changes nothing but still produces a response. ReadData is unchanged.
  - Load: ReadData takes the word as it was before that edge.
  - Misaligned request (latched Addr[1:0]≠0): the array is not accessed. ReadData is set to 0 and MemError is set to 1.
- RESP:
  - MemReady=1 for exactly one cycle. MemError is valid only in this cycle; it is 0 otherwise.
  - Next state is always IDLE. A request still present on MemReq in this RESP cycle is not accepted. The requester deasserts MemReq or presents a new request in the following cycle.
- MemBusy = (state==IDLE & MemReq) | (state==WAIT). It is 0 in RESP, which releases the stall in the same cycle the data is valid.
- Array contents are not cleared by reset.
- Reset mid-operation:
  - If reset is asserted before the edge entering RESP, the pending access is abandoned and no store lane is written.
  - State returns to IDLE.

## Timing
- Reset values: state=IDLE, counter=0, ReadData=0, MemReady=0, MemError=0, MemBusy=0.
- Request accepted in cycle T:
  - MemReady is high in cycle T+LATENCY+1.
  - ReadData is valid in that cycle and afterwards.
- Maximum throughput is one request every LATENCY+2 cycles.
- A load issued after a store to the same word returns the stored data.
- MemBusy is combinational from MemReq in IDLE. All other outputs are registered.

## Test plan
- **Store then load.** LATENCY=2.
  - Store 0xDEADBEEF to Addr 0x10, ByteEn=1111, accepted in cycle 0 → MemReady high in cycle 3, MemBusy high in cycles 0–2.
  - Load from 0x10 → ReadData=0xDEADBEEF with MemReady, MemError=0.
- **Byte-lane store.** Store WriteData 0x0000AA00 with ByteEn=0010 to 0x10 → a subsequent load returns 0xDEADAAEF. A store with ByteEn=0000 leaves the word at 0xDEADAAEF.
- **Misaligned access.** Load from 0x13 → MemReady with MemError=1 and ReadData=0. A store to 0x12 leaves word 0x10 unchanged.
- **Address aliasing.** DEPTH_LOG2=6. Store 0x12345678 to 0x100 → a load from 0x000 returns 0x12345678.
- **Reset mid-wait.** LATENCY=3. Word 0x20 holds 0x11111111. Store 0x22222222 to 0x20, accepted in cycle 0; assert reset (reset=0) in cycle 1 and release it in cycle 2 → all outputs are 0 immediately, MemReady is never pulsed for that store, and a later load from 0x20 returns 0x11111111.
- **Zero latency, back-to-back.** LATENCY=0. MemReq is held high with two successive loads → each MemReady arrives one cycle after acceptance, requests are accepted every second cycle, and no request is accepted in a RESP cycle.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline and dmem_responder.
//
// Handshake: the requester raises MemReq with MemWrite/Addr/WriteData/ByteEn
// stable and holds them until the responder pulses MemReady for one cycle.
// The responder latches the request in the cycle MemReq is seen while idle.
// MemReady, MemError and ReadData are registered and valid together. A request
// still asserted in the MemReady cycle is not taken. MemBusy asks the hazard
// unit to stall while a request is pending.
interface dmem_responder_if;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [3:0]  ByteEn;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemError;
    logic        MemBusy;

    modport master (
        output MemReq,
        output MemWrite,
        output Addr,
        output WriteData,
        output ByteEn,
        input  ReadData,
        input  MemReady,
        input  MemError,
        input  MemBusy
    );

    modport slave (
        input  MemReq,
        input  MemWrite,
        input  Addr,
        input  WriteData,
        input  ByteEn,
        output ReadData,
        output MemReady,
        output MemError,
        output MemBusy
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory for the pipeline memory stage. It takes one load
// or store at a time, waits LATENCY cycles, then answers with a one-cycle
// MemReady pulse. It supports byte-lane stores and flags misaligned accesses.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic [1:0]       o_dbg_state
);
    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] LAT   = 3'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_next;
    logic                  w_accept;
    logic                  w_enter_resp;

    // Latched copy of the accepted request.
    logic                  r_write;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_ben;

    // Response registers.
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  r_error;

    logic [31:0]           r_mem [DEPTH];

    // Fields used for the access on the edge that enters RESP.
    logic                  w_acc_write;
    logic [31:0]           w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic [3:0]            w_acc_ben;
    logic                  w_misaligned;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [31:0]           w_old_word;
    logic [31:0]           w_new_word;

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.MemReq) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = LAT;
                    w_state_next = (LAT == 3'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 3'd1;
                // The final decrement is from 1; <= also covers a stray 0.
                if (r_cnt <= 3'd1) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                // A request still present here is not taken.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_enter_resp = (w_state_next == S_RESP);

    // With zero latency the access happens on the accepting edge, so the live
    // request fields are used; otherwise the latched copy is used.
    always_comb begin
        w_acc_write = r_write;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        w_acc_ben   = r_ben;
        if (r_state == S_IDLE) begin
            w_acc_write = bus.MemWrite;
            w_acc_addr  = bus.Addr;
            w_acc_wdata = bus.WriteData;
            w_acc_ben   = bus.ByteEn;
        end
    end

    // Upper address bits are dropped, so addresses alias modulo the array.
    assign w_index      = w_acc_addr[DEPTH_LOG2+1:2];
    assign w_misaligned = |w_acc_addr[1:0];
    assign w_old_word   = r_mem[w_index];

    // Merge the enabled store lanes into the current word.
    always_comb begin
        w_new_word = w_old_word;
        for (int i = 0; i < 4; i++) begin
            if (w_acc_ben[i]) begin
                w_new_word[8*i +: 8] = w_acc_wdata[8*i +: 8];
            end
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_ben   <= 4'd0;
        end else if (w_accept) begin
            r_write <= bus.MemWrite;
            r_addr  <= bus.Addr;
            r_wdata <= bus.WriteData;
            r_ben   <= bus.ByteEn;
        end
    end

    // Response registers: ready/error pulse and load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= w_enter_resp;
            r_error <= w_enter_resp & w_misaligned;
            if (w_enter_resp) begin
                if (w_misaligned) begin
                    r_rdata <= 32'd0;
                end else if (!w_acc_write) begin
                    r_rdata <= w_old_word;
                end
            end
        end
    end

    // Array write. Reset never clears the contents; it only blocks a pending
    // store so that an abandoned access leaves every lane untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (reset && w_enter_resp && w_acc_write && !w_misaligned) begin
            r_mem[w_index] <= w_new_word;
        end
    end

    // Stall request: combinational from MemReq when idle, released in RESP.
    assign bus.MemBusy  = reset & (((r_state == S_IDLE) & bus.MemReq) | (r_state == S_WAIT));
    assign bus.ReadData = r_rdata;
    assign bus.MemReady = r_ready;
    assign bus.MemError = r_error;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 3 and 0) driven by
// directed requests; expected responses are queued and checked by a monitor.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  ben   [3];
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [2:0]  busy;
    logic [31:0] rdata [3];
    logic [1:0]  st    [3];

    int lat [3] = '{2, 3, 0};

    int n_checks = 0;
    int n_fail   = 0;

    // {instance[1:0], MemError, ReadData}
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.MemReq = req[0]; assign bus0.MemWrite = wr[0]; assign bus0.Addr = addr[0];
    assign bus0.WriteData = wdata[0]; assign bus0.ByteEn = ben[0];
    assign bus1.MemReq = req[1]; assign bus1.MemWrite = wr[1]; assign bus1.Addr = addr[1];
    assign bus1.WriteData = wdata[1]; assign bus1.ByteEn = ben[1];
    assign bus2.MemReq = req[2]; assign bus2.MemWrite = wr[2]; assign bus2.Addr = addr[2];
    assign bus2.WriteData = wdata[2]; assign bus2.ByteEn = ben[2];

    assign rdy[0] = bus0.MemReady; assign err[0] = bus0.MemError;
    assign busy[0] = bus0.MemBusy; assign rdata[0] = bus0.ReadData;
    assign rdy[1] = bus1.MemReady; assign err[1] = bus1.MemError;
    assign busy[1] = bus1.MemBusy; assign rdata[1] = bus1.ReadData;
    assign rdy[2] = bus2.MemReady; assign err[2] = bus2.MemError;
    assign busy[2] = bus2.MemBusy; assign rdata[2] = bus2.ReadData;

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .bus(bus0), .o_dbg_state(st[0]));
    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .bus(bus1), .o_dbg_state(st[1]));
    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(0)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .bus(bus2), .o_dbg_state(st[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every MemReady pulse must match the oldest expected response.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rdy[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: instance %0d pulsed MemReady, expected none", k);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_instance", 32'(k), 32'(mon_e[34:33]));
                    check("resp_data", rdata[k], mon_e[31:0]);
                    check("resp_error", 32'(err[k]), 32'(mon_e[32]));
                end
            end
        end
    end

    // Issue one request on instance k, queue its expected response, and check
    // MemBusy and the response latency while it is in flight.
    task automatic run_req(input int k, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be,
                           input logic [31:0] exp_d, input logic exp_e);
        int  n;
        bit  done;
        logic [1:0] kk;
        kk = k[1:0];
        @(posedge clk); #1;
        wr[k] = w; addr[k] = a; wdata[k] = d; ben[k] = be; req[k] = 1'b1;
        exp_q.push_back({kk, exp_e, exp_d});
        #1;
        check("busy_accept", 32'(busy[k]), 32'd1);
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (rdy[k] === 1'b1) done = 1'b1;
            else check("busy_wait", 32'(busy[k]), 32'd1);
        end
        check("resp_latency", 32'(n), 32'(lat[k] + 1));
        if (done) check("busy_in_resp", 32'(busy[k]), 32'd0);
        req[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 3'b000;
        req = 3'b000;
        wr = 3'b000;
        for (int k = 0; k < 3; k++) begin
            addr[k] = 32'd0; wdata[k] = 32'd0; ben[k] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", 32'(rdy[k]), 32'd0);
            check("reset_error", 32'(err[k]), 32'd0);
            check("reset_busy", 32'(busy[k]), 32'd0);
            check("reset_rdata", rdata[k], 32'd0);
            check("reset_state", 32'(st[k]), 32'd0);
        end
        rst_n = 3'b111;

        // Instance 0, LATENCY 2: store/load, byte lanes, misalignment, aliasing.
        run_req(0, 1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0);
        run_req(0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);
        run_req(0, 1'b1, 32'h10,  32'h0000AA00, 4'b0010, 32'hDEADBEEF, 1'b0);
        run_req(0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADAAEF, 1'b0);
        run_req(0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'b0000, 32'hDEADAAEF, 1'b0);
        run_req(0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADAAEF, 1'b0);
        run_req(0, 1'b0, 32'h13,  32'h0,        4'b0000, 32'h0,        1'b1);
        run_req(0, 1'b1, 32'h12,  32'h55555555, 4'b1111, 32'h0,        1'b1);
        run_req(0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADAAEF, 1'b0);
        run_req(0, 1'b1, 32'h100, 32'h12345678, 4'b1111, 32'hDEADAAEF, 1'b0);
        run_req(0, 1'b0, 32'h000, 32'h0,        4'b0000, 32'h12345678, 1'b0);

        // Instance 1, LATENCY 3: reset in the middle of the wait.
        run_req(1, 1'b1, 32'h20, 32'h11111111, 4'b1111, 32'h0,        1'b0);
        run_req(1, 1'b0, 32'h20, 32'h0,        4'b0000, 32'h11111111, 1'b0);
        @(posedge clk); #1;
        wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h22222222; ben[1] = 4'b1111; req[1] = 1'b1;
        @(posedge clk); #1;
        check("busy_before_reset", 32'(busy[1]), 32'd1);
        check("state_before_reset", 32'(st[1]), 32'd1);
        rst_n[1] = 1'b0;
        req[1] = 1'b0;
        #1;
        check("midreset_ready", 32'(rdy[1]), 32'd0);
        check("midreset_error", 32'(err[1]), 32'd0);
        check("midreset_busy", 32'(busy[1]), 32'd0);
        check("midreset_rdata", rdata[1], 32'd0);
        check("midreset_state", 32'(st[1]), 32'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("after_reset_state", 32'(st[1]), 32'd0);
        run_req(1, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11111111, 1'b0);

        // Instance 2, LATENCY 0: back-to-back loads with MemReq held high.
        run_req(2, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0);
        run_req(2, 1'b1, 32'h44, 32'h5A5A5A5A, 4'b1111, 32'h0, 1'b0);
        @(posedge clk); #1;
        wr[2] = 1'b0; addr[2] = 32'h40; ben[2] = 4'b0000; req[2] = 1'b1;
        exp_q.push_back({2'd2, 1'b0, 32'hA5A5A5A5});
        #1;
        check("b2b_busy_first", 32'(busy[2]), 32'd1);
        @(posedge clk); #1;
        check("b2b_ready_first", 32'(rdy[2]), 32'd1);
        check("b2b_state_resp", 32'(st[2]), 32'd2);
        check("b2b_busy_resp", 32'(busy[2]), 32'd0);
        @(posedge clk); #1;
        check("b2b_no_accept_in_resp", 32'(rdy[2]), 32'd0);
        check("b2b_state_idle", 32'(st[2]), 32'd0);
        addr[2] = 32'h44;
        exp_q.push_back({2'd2, 1'b0, 32'h5A5A5A5A});
        #1;
        check("b2b_busy_second", 32'(busy[2]), 32'd1);
        @(posedge clk); #1;
        check("b2b_ready_second", 32'(rdy[2]), 32'd1);
        req[2] = 1'b0;
        @(posedge clk); #1;
        check("b2b_ready_drop", 32'(rdy[2]), 32'd0);
        check("b2b_state_end", 32'(st[2]), 32'd0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
